// File: rtl/qam_pkg.sv
// Shared definitions for the QAM-16 transmit frame sequencer.
//   tx_state_t     : frame sequencer state encoding
//   SYM_ZERO/PRE/PAY : sym_sel encodings driven towards the symbol source
//   max3()         : helper used to size the shared symbol counter
package qam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        PREAMBLE,
        PAYLOAD,
        GUARD,
        ERROR
    } tx_state_t;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_PRE  = 2'b01;
    localparam logic [1:0] SYM_PAY  = 2'b10;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qam_tx_ctrl_if.sv
// Control/status bundle between the frame sequencer and its environment.
//   master : the sequencer (drives sym_tick, sym_sel, sym_idx, mod_en, busy,
//            frame_done, error; samples start, stop and the three valids)
//   slave  : software/bench control plus the datapath valids
// Optional statistics ports (frame_count, err_count) exist only when
// QAM_TX_CTRL_STATS_EN is defined.
interface qam_tx_ctrl_if;
    logic        start;
    logic        stop;
    logic        fir_i_valid;
    logic        fir_q_valid;
    logic        cordic_valid;
    logic        sym_tick;
    logic [1:0]  sym_sel;
    logic [15:0] sym_idx;
    logic        mod_en;
    logic        busy;
    logic        frame_done;
    logic        error;
`ifdef QAM_TX_CTRL_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    modport master (
        input  start, stop, fir_i_valid, fir_q_valid, cordic_valid,
        output sym_tick, sym_sel, sym_idx, mod_en, busy, frame_done, error,
        output frame_count, err_count
    );
    modport slave (
        output start, stop, fir_i_valid, fir_q_valid, cordic_valid,
        input  sym_tick, sym_sel, sym_idx, mod_en, busy, frame_done, error,
        input  frame_count, err_count
    );
`else
    modport master (
        input  start, stop, fir_i_valid, fir_q_valid, cordic_valid,
        output sym_tick, sym_sel, sym_idx, mod_en, busy, frame_done, error
    );
    modport slave (
        output start, stop, fir_i_valid, fir_q_valid, cordic_valid,
        input  sym_tick, sym_sel, sym_idx, mod_en, busy, frame_done, error
    );
`endif
endinterface

// File: rtl/qam_tx_ctrl_sym_tick_gen.sv
// sym_tick_gen: symbol-period divider counting 0..UPSAMPLE-1.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : restart the period at count 0 on the next cycle (wins over en)
//   en         : divider runs this cycle
//   tick       : first cycle of a symbol period (count 0 while enabled)
//   last       : final cycle of a symbol period (count UPSAMPLE-1 while enabled)
module sym_tick_gen #(
    parameter int unsigned UPSAMPLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic last
);
    localparam int unsigned CNT_W = (UPSAMPLE > 2) ? $clog2(UPSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPSAMPLE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        tick = en && (cnt == '0);
        last = en && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/qam_tx_ctrl.sv
// qam_tx_ctrl: frame sequencer for the QAM-16 transmit chain.
// Waits for both FIRs and the carrier CORDIC to report valid, then runs
// back-to-back frames of PREAMBLE / PAYLOAD / GUARD symbols, one symbol
// every UPSAMPLE cycles, until a stop request completes the current frame.
// Any valid drop during PREAMBLE or PAYLOAD (or a warm-up timeout) parks the
// block in ERROR until the next start.
//   clk, reset : clock, asynchronous active-high reset
//   tx         : qam_tx_ctrl_if.master (start/stop/valids in; sym_tick,
//                sym_sel, sym_idx, mod_en, busy, frame_done, error out)
// Define QAM_TX_CTRL_STATS_EN to add frame_count (wrapping) and err_count
// (saturating) on the interface.
module qam_tx_ctrl
    import qam_pkg::*;
#(
    parameter int unsigned UPSAMPLE      = 4,
    parameter int unsigned PREAMBLE_SYMS = 16,
    parameter int unsigned PAYLOAD_SYMS  = 256,
    parameter int unsigned GUARD_SYMS    = 8,
    parameter int unsigned WARMUP_MAX    = 1024
) (
    input  logic          clk,
    input  logic          reset,
    qam_tx_ctrl_if.master tx
);
    localparam int unsigned SYM_W  = $clog2(max3(PREAMBLE_SYMS, PAYLOAD_SYMS, GUARD_SYMS) + 1);
    localparam int unsigned WARM_W = $clog2(WARMUP_MAX + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_MAX - 1);

    tx_state_t         state;
    logic [SYM_W-1:0]  sym_cnt;
    logic [SYM_W-1:0]  phase_last;
    logic [WARM_W-1:0] warm_cnt;
    logic              stop_latch;

    logic valids_ok, in_phase, busy_state, stop_pending;
    logic div_clr, div_tick, div_last;
    logic phase_end, warm_expired, pipe_fault, enter_err, frame_end;

    always_comb begin
        valids_ok    = tx.fir_i_valid & tx.fir_q_valid & tx.cordic_valid;
        in_phase     = state inside {PREAMBLE, PAYLOAD, GUARD};
        busy_state   = (state != IDLE) && (state != ERROR);
        // A stop arriving in the final GUARD cycle still ends this frame.
        stop_pending = stop_latch | tx.stop;
        case (state)
            PREAMBLE: phase_last = SYM_W'(PREAMBLE_SYMS - 1);
            PAYLOAD:  phase_last = SYM_W'(PAYLOAD_SYMS - 1);
            GUARD:    phase_last = SYM_W'(GUARD_SYMS - 1);
            default:  phase_last = '0;
        endcase
        phase_end    = in_phase && div_last && (sym_cnt == phase_last);
        // Holding the divider clear outside the phases and across every phase
        // boundary guarantees count 0 in the first cycle of each phase.
        div_clr      = !in_phase || phase_end;
        warm_expired = (state == WARMUP) && !valids_ok && (warm_cnt == WARM_LAST);
        pipe_fault   = ((state == PREAMBLE) || (state == PAYLOAD)) && !valids_ok;
        enter_err    = warm_expired || pipe_fault;
        frame_end    = (state == GUARD) && phase_end;
    end

    sym_tick_gen #(
        .UPSAMPLE(UPSAMPLE)
    ) u_sym_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (div_clr),
        .en   (in_phase),
        .tick (div_tick),
        .last (div_last)
    );

    assign tx.sym_idx = 16'(sym_cnt);

    // Outputs are computed for the state being entered, so sym_tick leads
    // the divider decode by one edge and lines up with count 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sym_cnt       <= '0;
            warm_cnt      <= '0;
            stop_latch    <= 1'b0;
            tx.sym_tick   <= 1'b0;
            tx.sym_sel    <= SYM_ZERO;
            tx.mod_en     <= 1'b0;
            tx.busy       <= 1'b0;
            tx.frame_done <= 1'b0;
            tx.error      <= 1'b0;
        end else begin
            tx.sym_tick   <= 1'b0;
            tx.frame_done <= 1'b0;
            if (tx.stop && busy_state) begin
                stop_latch <= 1'b1;
            end
            if (enter_err) begin
                state      <= ERROR;
                sym_cnt    <= '0;
                tx.sym_sel <= SYM_ZERO;
                tx.mod_en  <= 1'b0;
                tx.busy    <= 1'b0;
                tx.error   <= 1'b1;
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        if (tx.start) begin
                            state      <= WARMUP;
                            warm_cnt   <= '0;
                            stop_latch <= tx.stop;
                            tx.busy    <= 1'b1;
                            tx.error   <= 1'b0;
                        end
                    end
                    WARMUP: begin
                        if (valids_ok) begin
                            state       <= PREAMBLE;
                            sym_cnt     <= '0;
                            tx.sym_tick <= 1'b1;
                            tx.sym_sel  <= SYM_PRE;
                            tx.mod_en   <= 1'b1;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                    end
                    PREAMBLE, PAYLOAD, GUARD: begin
                        if (phase_end) begin
                            sym_cnt <= '0;
                            if (state == PREAMBLE) begin
                                state       <= PAYLOAD;
                                tx.sym_sel  <= SYM_PAY;
                                tx.sym_tick <= 1'b1;
                            end else if (state == PAYLOAD) begin
                                state       <= GUARD;
                                tx.sym_sel  <= SYM_ZERO;
                                tx.sym_tick <= 1'b1;
                            end else begin
                                tx.frame_done <= 1'b1;
                                if (stop_pending) begin
                                    state      <= IDLE;
                                    stop_latch <= 1'b0;
                                    tx.mod_en  <= 1'b0;
                                    tx.busy    <= 1'b0;
                                end else begin
                                    state       <= PREAMBLE;
                                    tx.sym_sel  <= SYM_PRE;
                                    tx.sym_tick <= 1'b1;
                                end
                            end
                        end else if (div_last) begin
                            sym_cnt     <= sym_cnt + 1'b1;
                            tx.sym_tick <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    a_tick_align: assert property (@(posedge clk) disable iff (reset) tx.sym_tick == div_tick);

`ifdef QAM_TX_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx.frame_count <= '0;
            tx.err_count   <= '0;
        end else begin
            if (frame_end) begin
                tx.frame_count <= tx.frame_count + 1'b1;
            end
            if (enter_err && (tx.err_count != 8'hFF)) begin
                tx.err_count <= tx.err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qam_tx_ctrl.sv
// Directed, table-driven bench for qam_tx_ctrl with a small frame model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Statistics checks are compiled in when QAM_TX_CTRL_STATS_EN is defined.
module tb_qam_tx_ctrl;
    localparam int UP   = 4;
    localparam int NPRE = 2;
    localparam int NPAY = 4;
    localparam int NGRD = 1;
    localparam int FRAME = (NPRE + NPAY + NGRD) * UP;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_frames = 0;
    int   exp_errs = 0;

    qam_tx_ctrl_if tif ();

    qam_tx_ctrl #(
        .UPSAMPLE     (UP),
        .PREAMBLE_SYMS(NPRE),
        .PAYLOAD_SYMS (NPAY),
        .GUARD_SYMS   (NGRD),
        .WARMUP_MAX   (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tx   (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, stop, fi, fq, fc;
        logic        tick;
        logic [1:0]  sel;
        logic [15:0] idx;
        logic        me, busy, fd, err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic tick, input logic [1:0] sel,
                           input logic [15:0] idx, input logic me, input logic busy,
                           input logic fd, input logic err);
        chk({tag, ".sym_tick"}, 16'(tif.sym_tick), 16'(tick));
        chk({tag, ".sym_sel"}, 16'(tif.sym_sel), 16'(sel));
        chk({tag, ".sym_idx"}, tif.sym_idx, idx);
        chk({tag, ".mod_en"}, 16'(tif.mod_en), 16'(me));
        chk({tag, ".busy"}, 16'(tif.busy), 16'(busy));
        chk({tag, ".frame_done"}, 16'(tif.frame_done), 16'(fd));
        chk({tag, ".error"}, 16'(tif.error), 16'(err));
    endtask

    task automatic chk_stats(input string tag);
`ifdef QAM_TX_CTRL_STATS_EN
        chk({tag, ".frame_count"}, tif.frame_count, 16'(exp_frames));
        chk({tag, ".err_count"}, 16'(tif.err_count), 16'(exp_errs));
`else
        chk({tag, ".no_stats_busy"}, 16'(tif.busy), 16'(tif.mod_en));
`endif
    endtask

    // Expected outputs at cycle offset o (0..FRAME-1) inside a running frame.
    task automatic chk_frame(input int o);
        logic [1:0] sel;
        int idx;
        if (o < NPRE * UP) begin
            sel = 2'b01; idx = o / UP;
        end else if (o < (NPRE + NPAY) * UP) begin
            sel = 2'b10; idx = (o - NPRE * UP) / UP;
        end else begin
            sel = 2'b00; idx = (o - (NPRE + NPAY) * UP) / UP;
        end
        chk_all($sformatf("frame_o%0d", o), (o % UP) == 0, sel, 16'(idx), 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Precondition: at a falling edge showing offset lo-1. Pulses are driven
    // during the cycle showing the given offset (-1 disables).
    task automatic run_frame(input int lo, input int hi, input int stop_off,
                             input int start_off, input int fi_drop_off);
        for (int o = lo; o <= hi; o++) begin
            tif.stop        = (o - 1 == stop_off);
            tif.start       = (o - 1 == start_off);
            tif.fir_i_valid = !(o - 1 == fi_drop_off);
            @(negedge clk);
            chk_frame(o);
        end
        tif.stop = 1'b0;
        tif.start = 1'b0;
        tif.fir_i_valid = 1'b1;
    endtask

    // From IDLE or ERROR with valids high: one WARMUP cycle, then PREAMBLE.
    task automatic start_frame(input logic with_stop, input string tag);
        tif.start = 1'b1; tif.stop = with_stop;
        tif.fir_i_valid = 1'b1; tif.fir_q_valid = 1'b1; tif.cordic_valid = 1'b1;
        @(negedge clk);
        chk_all({tag, "_warmup"}, 1'b0, 2'b00, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tif.start = 1'b0; tif.stop = 1'b0;
        @(negedge clk);
        chk_frame(0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i < 5; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 6; i < 9; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};

        tif.start = 1'b0; tif.stop = 1'b0;
        tif.fir_i_valid = 1'b0; tif.fir_q_valid = 1'b0; tif.cordic_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("in_reset", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk_all("after_reset", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("after_reset");

        // Lone stop in IDLE is ignored.
        tif.stop = 1'b1;
        @(negedge clk);
        tif.stop = 1'b0;
        chk_all("idle_stop", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start, valids rise 5 cycles later, first symbols of frame 1.
        for (int i = 0; i < 10; i++) begin
            tif.start = tbl[i].start; tif.stop = tbl[i].stop;
            tif.fir_i_valid = tbl[i].fi; tif.fir_q_valid = tbl[i].fq; tif.cordic_valid = tbl[i].fc;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].tick, tbl[i].sel, tbl[i].idx,
                    tbl[i].me, tbl[i].busy, tbl[i].fd, tbl[i].err);
        end
        run_frame(5, FRAME - 1, -1, -1, -1);

        // Frame boundary: frame_done together with frame 2 offset 0.
        @(negedge clk);
        exp_frames++;
        chk_all("frame1_done", 1'b1, 2'b01, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Frame 2 with stop mid-payload: completes, then IDLE.
        run_frame(1, FRAME - 1, 13, -1, -1);
        @(negedge clk);
        exp_frames++;
        chk_all("frame2_done_idle", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("idle_after_stop", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Warm-up timeout: 16 WARMUP cycles, then ERROR.
        tif.fir_i_valid = 1'b0; tif.fir_q_valid = 1'b0; tif.cordic_valid = 1'b0;
        tif.start = 1'b1;
        @(negedge clk);
        tif.start = 1'b0;
        for (int w = 1; w < 16; w++) begin
            @(negedge clk);
            chk_all($sformatf("warm%0d", w), 1'b0, 2'b00, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        exp_errs++;
        chk_all("warm_timeout", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start from ERROR clears error and re-enters WARMUP.
        tif.start = 1'b1;
        @(negedge clk);
        tif.start = 1'b0;
        chk_all("restart_warmup", 1'b0, 2'b00, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tif.fir_i_valid = 1'b1; tif.fir_q_valid = 1'b1; tif.cordic_valid = 1'b1;
        @(negedge clk);
        chk_frame(0);

        // fir_q_valid drops in PAYLOAD cycle 2 -> ERROR, no more ticks.
        run_frame(1, NPRE * UP + 1, -1, -1, -1);
        tif.fir_q_valid = 1'b0;
        @(negedge clk);
        exp_errs++;
        chk_all("q_drop_err", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tif.fir_q_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("err_no_tick%0d", c), 16'(tif.sym_tick), 16'd0);
        end

        // Start while busy ignored; cordic drop in the last PAYLOAD cycle wins.
        start_frame(1'b0, "frameB");
        run_frame(1, (NPRE + NPAY) * UP - 1, -1, 3, -1);
        tif.cordic_valid = 1'b0;
        @(negedge clk);
        exp_errs++;
        chk_all("last_pay_drop", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tif.cordic_valid = 1'b1;

        // Valid drop in GUARD ignored; stop during GUARD ends this frame.
        start_frame(1'b0, "frameC");
        run_frame(1, FRAME - 1, FRAME - 2, -1, (NPRE + NPAY) * UP + 1);
        @(negedge clk);
        exp_frames++;
        chk_all("frameC_done_idle", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // start together with stop in IDLE: exactly one frame.
        start_frame(1'b1, "frameD");
        run_frame(1, FRAME - 1, -1, -1, -1);
        @(negedge clk);
        exp_frames++;
        chk_all("frameD_done_idle", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_all("frameD_idle", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("stats");

        // Reset mid-frame clears everything at once.
        start_frame(1'b0, "frameE");
        run_frame(1, 10, -1, -1, -1);
        reset = 1'b1;
        #1;
        exp_frames = 0;
        exp_errs = 0;
        chk_all("mid_reset", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all("post_reset_idle", 1'b0, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qam_tx_ctrl.md
# qam_tx_ctrl

Frame sequencer for the QAM-16 transmit chain. It runs the PRBS/symbol-map/upsample front end in framed bursts (preamble, payload, guard) and waits for the CORDIC carrier and both pulse-shaping FIRs to report valid before releasing symbols. It gates the modulator output and flags pipeline faults. It sits beside the transmit datapath, between software/bench control and the symbol source.

## Interface
- UPSAMPLE, 4: clock cycles per symbol (≥2).
- PREAMBLE_SYMS, 16: preamble symbols per frame (≥1).
- PAYLOAD_SYMS, 256: payload symbols per frame (≥1).
- GUARD_SYMS, 8: zero symbols after payload (≥1).
- WARMUP_MAX, 1024: cycles allowed for valids to rise before fault.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins operation from IDLE or ERROR.
- stop  in  1  pulse; request to end after the current frame.
- fir_i_valid  in  1  I-branch FIR output valid.
- fir_q_valid  in  1  Q-branch FIR output valid.
- cordic_valid  in  1  carrier CORDIC output valid.
- sym_tick  out  1  one-cycle strobe that advances the symbol source.
- sym_sel  out  2  00 zero symbol, 01 preamble, 10 payload.
- sym_idx  out  16  symbol index within the current phase.
- mod_en  out  1  modulator/combiner output enable.
- busy  out  1  high in every state except IDLE and ERROR.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- error  out  1  sticky fault flag.

## Operation
- States: IDLE, WARMUP, PREAMBLE, PAYLOAD, GUARD, ERROR. All outputs are registered.
- Reset: state IDLE, all outputs 0, counters 0, stop latch cleared.
- IDLE: a start pulse moves the block to WARMUP. A stop pulse in IDLE is ignored.
- WARMUP: a cycle counter runs.
  - If fir_i_valid & fir_q_valid & cordic_valid are all high in the same cycle, go to PREAMBLE.
  - If the counter reaches WARMUP_MAX-1 first, go to ERROR.
- PREAMBLE, PAYLOAD, GUARD:
  - A divider counts 0..UPSAMPLE-1. sym_tick is high when the count is 0, starting in the first cycle of each phase.
  - sym_idx counts ticks within the phase and resets to 0 on each phase entry.
  - A phase ends after its N-th symbol period completes, i.e. N*UPSAMPLE cycles.
  - mod_en is 1 in all three phases. GUARD drives sym_sel=00 so the filter tails flush.
- Leaving GUARD:
  - frame_done pulses for one cycle.
  - If the stop latch is set, go to IDLE and clear the latch.
  - Otherwise go straight to PREAMBLE for the next frame, with no warm-up.
- stop is latched in any busy state and takes effect only at the end of a frame.
- If any valid input drops in PREAMBLE or PAYLOAD, go to ERROR in the next cycle. A valid drop during GUARD is ignored.
- ERROR: error=1, mod_en=0, sym_tick=0. A start pulse clears error and moves to WARMUP.
- Simultaneous events:
  - start together with stop in IDLE gives exactly one frame.
  - A valid drop in the last cycle of PAYLOAD takes priority and goes to ERROR.
  - start while busy is ignored.

## Timing
- start sampled high at edge 0: WARMUP and busy=1 from edge 1.
- All valids high at edge k: PREAMBLE at edge k+1, with sym_tick=1, sym_sel=01, sym_idx=0 and mod_en=1 in that same cycle.
- One frame is (PREAMBLE_SYMS+PAYLOAD_SYMS+GUARD_SYMS)*UPSAMPLE cycles. Back-to-back frames have no gap.
- frame_done is high in the first cycle after the last GUARD cycle, coincident with the new state.
- Counters are as wide as needed for the parameters. sym_idx is zero-extended to 16 bits.

## Configuration
- QAM_TX_CTRL_STATS_EN defined:
  - Adds output frame_count[15:0], which increments on frame_done and wraps at 65535→0.
  - Adds output err_count[7:0], which increments on each ERROR entry and saturates at 255.
  - Both reset to 0.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package qam_pkg holds:
  - the state enum, tx_state_t;
  - sym_sel encodings SYM_ZERO, SYM_PRE, SYM_PAY.
- Sub-module sym_tick_gen is the UPSAMPLE divider:
  - inputs clr and en;
  - outputs tick and last, where last means the final cycle of a symbol period.

## Test plan
Bench parameters: UPSAMPLE=4, PREAMBLE_SYMS=2, PAYLOAD_SYMS=4, GUARD_SYMS=1, WARMUP_MAX=16.
- Reset held, then released with inputs idle -> all outputs 0, state IDLE.
- start; valids rise 5 cycles later -> PREAMBLE 1 cycle after the valids. sym_tick at cycle offsets 0,4,8,… with sym_sel 01,01,10,10,10,10,00. frame_done exactly 28 cycles after PREAMBLE entry.
- start with no stop -> second frame begins in the cycle after frame_done with sym_idx=0. Then stop mid-payload -> current frame completes, then IDLE and busy=0.
- start with valids held low -> error=1 after 16 WARMUP cycles, then start clears error and re-enters WARMUP.
- fir_q_valid drops in cycle 2 of PAYLOAD -> ERROR the next cycle, mod_en=0, no further sym_tick.
- With QAM_TX_CTRL_STATS_EN: 3 frames then 1 fault -> frame_count=3, err_count=1. A reset mid-frame -> all outputs and counts 0 immediately.
